// File: rtl/hazard_sched_ctrl.sv
// Central pipeline scheduler for the 5-stage RISC-V core.
// Sequences the EX/MEM data-memory access through a req/ready handshake
// with a timeout, detects load-use hazards, applies MEM-stage redirects,
// and drives every pipeline-register stall/flush.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs1/rs2, id_uses_*    source registers of the ID instruction
//   ex_rd, ex_mem_read       destination / load flag of the EX instruction
//   mem_mem_read/write       access type held in EX/MEM
//   redirect_mem             taken branch/jump resolved in MEM
//   dmem_ready               data memory completes current access
//   dmem_req, dmem_we        data memory request / store flag
//   stall_*, flush_*         pipeline register controls
//   mem_err                  sticky access-timeout error
//   stall_cycles             saturating count of stalled cycles
module hazard_sched_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             mem_mem_read,
    input  logic             mem_mem_write,
    input  logic             redirect_mem,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             flush_mem_wb,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               mem_err_q;
    logic [CNT_W-1:0]   stall_cycles_q;

    logic mem_op;
    logic load_use;
    logic mem_stall;
    logic any_stall;

    assign mem_op   = mem_mem_read | mem_mem_write;
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Next-state and combinational stall/flush decode; all zero while in reset.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        mem_stall    = 1'b0;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;

        if (!rst) begin
            case (state_q)
                RUN: begin
                    dmem_req = mem_op;
                    dmem_we  = mem_mem_write;
                    if (mem_op && !dmem_ready) begin
                        state_d = MEM_WAIT;
                        wcnt_d  = WCNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    dmem_req = 1'b1;
                    dmem_we  = mem_mem_write;
                    if (dmem_ready) begin
                        state_d = RUN;
                        wcnt_d  = '0;
                    end else if (wcnt_q == WCNT_LAST) begin
                        state_d = ERR;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
                default: ;
            endcase

            mem_stall = dmem_req && !dmem_ready;

            if (state_q == ERR) begin
                // Freeze the front of the pipe until reset.
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_mem = 1'b1;
            end else if (mem_stall) begin
                // Redirect waits: EX/MEM is held, so it is seen again on release.
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_mem = 1'b1;
                flush_mem_wb = 1'b1;
            end else if (redirect_mem) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end else if (load_use) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
            end
        end
    end

    assign any_stall = stall_pc | stall_if_id | stall_id_ex | stall_ex_mem;

    // State, wait counter, sticky error and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            wcnt_q         <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= (state_d == ERR);
            if (any_stall && !(&stall_cycles_q)) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
        end
    end

    assign mem_err      = mem_err_q && !rst;
    assign stall_cycles = rst ? '0 : stall_cycles_q;

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Directed bench for hazard_sched_ctrl. Two instances share stimulus:
// dut_a uses default parameters, dut_b uses MEM_TIMEOUT=4, CNT_W=3.
// Output vector bit order: req we spc sif sie sem fif fie fem fmw err.
module tb_hazard_sched_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic       mem_mem_read, mem_mem_write, redirect_mem, dmem_ready;

    logic        a_req, a_we, a_spc, a_sif, a_sie, a_sem, a_fif, a_fie, a_fem, a_fmw, a_err;
    logic [31:0] a_stall_cycles;
    logic        b_req, b_we, b_spc, b_sif, b_sie, b_sem, b_fif, b_fie, b_fem, b_fmw, b_err;
    logic [2:0]  b_stall_cycles;

    logic [10:0] a_vec, b_vec;
    assign a_vec = {a_req, a_we, a_spc, a_sif, a_sie, a_sem, a_fif, a_fie, a_fem, a_fmw, a_err};
    assign b_vec = {b_req, b_we, b_spc, b_sif, b_sie, b_sem, b_fif, b_fie, b_fem, b_fmw, b_err};

    localparam logic [10:0] V_IDLE      = 11'b00000000000;
    localparam logic [10:0] V_LD_GO     = 11'b10000000000;
    localparam logic [10:0] V_ST_GO     = 11'b11000000000;
    localparam logic [10:0] V_LD_STALL  = 11'b10111100010;
    localparam logic [10:0] V_ST_STALL  = 11'b11111100010;
    localparam logic [10:0] V_LOAD_USE  = 11'b00110001000;
    localparam logic [10:0] V_REDIRECT  = 11'b00000011100;
    localparam logic [10:0] V_LD_REDIR  = 11'b10000011100;
    localparam logic [10:0] V_ERR       = 11'b00111100001;

    int checks   = 0;
    int failures = 0;

    hazard_sched_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .redirect_mem(redirect_mem), .dmem_ready(dmem_ready),
        .dmem_req(a_req), .dmem_we(a_we),
        .stall_pc(a_spc), .stall_if_id(a_sif), .stall_id_ex(a_sie), .stall_ex_mem(a_sem),
        .flush_if_id(a_fif), .flush_id_ex(a_fie), .flush_ex_mem(a_fem), .flush_mem_wb(a_fmw),
        .mem_err(a_err), .stall_cycles(a_stall_cycles)
    );

    hazard_sched_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .redirect_mem(redirect_mem), .dmem_ready(dmem_ready),
        .dmem_req(b_req), .dmem_we(b_we),
        .stall_pc(b_spc), .stall_if_id(b_sif), .stall_id_ex(b_sie), .stall_ex_mem(b_sem),
        .flush_if_id(b_fif), .flush_id_ex(b_fie), .flush_ex_mem(b_fem), .flush_mem_wb(b_fmw),
        .mem_err(b_err), .stall_cycles(b_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        mem_mem_read = 1'b0; mem_mem_write = 1'b0;
        redirect_mem = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        mem_mem_read = 1'b1; redirect_mem = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        tick();
        tick();
        checks++;
        if (a_vec !== V_IDLE) begin
            failures++; $display("FAIL reset_a_outputs got=%b exp=%b", a_vec, V_IDLE);
        end
        checks++;
        if (b_vec !== V_IDLE) begin
            failures++; $display("FAIL reset_b_outputs got=%b exp=%b", b_vec, V_IDLE);
        end
        clear_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if (a_vec !== V_IDLE) begin
            failures++; $display("FAIL post_reset_outputs got=%b exp=%b", a_vec, V_IDLE);
        end
        checks++;
        if (a_stall_cycles !== 32'd0) begin
            failures++; $display("FAIL post_reset_count got=%0d exp=0", a_stall_cycles);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        mem_mem_read = 1'b1; dmem_ready = 1'b1;
        #1;
        checks++;
        if (a_vec !== V_LD_GO) begin
            failures++; $display("FAIL zero_wait_load got=%b exp=%b", a_vec, V_LD_GO);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (a_vec !== V_IDLE) begin
            failures++; $display("FAIL zero_wait_after got=%b exp=%b", a_vec, V_IDLE);
        end
        checks++;
        if (a_stall_cycles !== 32'd0) begin
            failures++; $display("FAIL zero_wait_count got=%0d exp=0", a_stall_cycles);
        end
    endtask

    task automatic test_store_wait();
        do_reset();
        mem_mem_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (a_vec !== V_ST_STALL) begin
                failures++; $display("FAIL store_wait_c%0d got=%b exp=%b", i, a_vec, V_ST_STALL);
            end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (a_vec !== V_ST_GO) begin
            failures++; $display("FAIL store_ready got=%b exp=%b", a_vec, V_ST_GO);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (a_vec !== V_IDLE) begin
            failures++; $display("FAIL store_after got=%b exp=%b", a_vec, V_IDLE);
        end
        checks++;
        if (a_stall_cycles !== 32'd3) begin
            failures++; $display("FAIL store_count_a got=%0d exp=3", a_stall_cycles);
        end
        checks++;
        if (b_stall_cycles !== 3'd3) begin
            failures++; $display("FAIL store_count_b got=%0d exp=3", b_stall_cycles);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
        #1;
        checks++;
        if (a_vec !== V_LOAD_USE) begin
            failures++; $display("FAIL load_use_rs2 got=%b exp=%b", a_vec, V_LOAD_USE);
        end
        tick();
        ex_rd = 5'd0; id_rs2 = 5'd0;
        #1;
        checks++;
        if (a_vec !== V_IDLE) begin
            failures++; $display("FAIL load_use_x0 got=%b exp=%b", a_vec, V_IDLE);
        end
        ex_rd = 5'd9; id_rs2 = 5'd5;
        #1;
        checks++;
        if (a_vec !== V_LOAD_USE) begin
            failures++; $display("FAIL load_use_rs1 got=%b exp=%b", a_vec, V_LOAD_USE);
        end
        id_uses_rs1 = 1'b0;
        #1;
        checks++;
        if (a_vec !== V_IDLE) begin
            failures++; $display("FAIL load_use_unused got=%b exp=%b", a_vec, V_IDLE);
        end
        id_uses_rs1 = 1'b1; ex_mem_read = 1'b0;
        #1;
        checks++;
        if (a_vec !== V_IDLE) begin
            failures++; $display("FAIL load_use_noload got=%b exp=%b", a_vec, V_IDLE);
        end
        tick();
        checks++;
        if (a_stall_cycles !== 32'd1) begin
            failures++; $display("FAIL load_use_count got=%0d exp=1", a_stall_cycles);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        redirect_mem = 1'b1;
        #1;
        checks++;
        if (a_vec !== V_REDIRECT) begin
            failures++; $display("FAIL redirect_over_load_use got=%b exp=%b", a_vec, V_REDIRECT);
        end
        clear_inputs();
        mem_mem_read = 1'b1; redirect_mem = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (a_vec !== V_LD_STALL) begin
                failures++; $display("FAIL redirect_in_wait_c%0d got=%b exp=%b", i, a_vec, V_LD_STALL);
            end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (a_vec !== V_LD_REDIR) begin
            failures++; $display("FAIL redirect_on_ready got=%b exp=%b", a_vec, V_LD_REDIR);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (a_stall_cycles !== 32'd2) begin
            failures++; $display("FAIL redirect_count got=%0d exp=2", a_stall_cycles);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_mem_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (b_vec !== V_LD_STALL) begin
                failures++; $display("FAIL timeout_wait_c%0d got=%b exp=%b", i, b_vec, V_LD_STALL);
            end
            tick();
        end
        checks++;
        if (b_vec !== V_ERR) begin
            failures++; $display("FAIL timeout_err_entry got=%b exp=%b", b_vec, V_ERR);
        end
        checks++;
        if (a_vec !== V_LD_STALL) begin
            failures++; $display("FAIL timeout_long_still_waiting got=%b exp=%b", a_vec, V_LD_STALL);
        end
        checks++;
        if (b_stall_cycles !== 3'd4) begin
            failures++; $display("FAIL timeout_count got=%0d exp=4", b_stall_cycles);
        end
        clear_inputs();
        dmem_ready = 1'b1;
        tick();
        checks++;
        if (b_vec !== V_ERR) begin
            failures++; $display("FAIL timeout_err_sticky got=%b exp=%b", b_vec, V_ERR);
        end
        checks++;
        if (b_stall_cycles !== 3'd5) begin
            failures++; $display("FAIL timeout_err_count got=%0d exp=5", b_stall_cycles);
        end
        clear_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (b_vec !== V_IDLE || b_stall_cycles !== 3'd0) begin
            failures++; $display("FAIL timeout_in_rst got=%b/%0d exp=%b/0", b_vec, b_stall_cycles, V_IDLE);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (b_vec !== V_IDLE || b_err !== 1'b0) begin
            failures++; $display("FAIL timeout_after_rst got=%b exp=%b", b_vec, V_IDLE);
        end
        checks++;
        if (a_vec !== V_IDLE) begin
            failures++; $display("FAIL rst_mid_wait got=%b exp=%b", a_vec, V_IDLE);
        end
        mem_mem_read = 1'b1; dmem_ready = 1'b1;
        #1;
        checks++;
        if (b_vec !== V_LD_GO) begin
            failures++; $display("FAIL timeout_run_again got=%b exp=%b", b_vec, V_LD_GO);
        end
        clear_inputs();
    endtask

    task automatic test_saturate();
        int exp_b;
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_uses_rs1 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp_b = (i > 7) ? 7 : i;
            checks++;
            if (b_stall_cycles !== 3'(exp_b)) begin
                failures++; $display("FAIL saturate_b_c%0d got=%0d exp=%0d", i, b_stall_cycles, exp_b);
            end
            checks++;
            if (a_stall_cycles !== 32'(i)) begin
                failures++; $display("FAIL saturate_a_c%0d got=%0d exp=%0d", i, a_stall_cycles, i);
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_zero_wait();
        test_store_wait();
        test_load_use();
        test_redirect();
        test_timeout();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_sched_ctrl.md
Name: hazard_sched_ctrl

Overview:
- Central pipeline scheduler for the 5-stage RISC-V core.
- Sequences the data-memory access held in the EX/MEM register through a req/ready handshake with a timeout FSM.
- Detects load-use hazards and applies branch/jump redirects resolved in MEM.
- Drives every stall and flush input of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps a saturating stall-cycle counter.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before abort (>=2).
- CNT_W, 32, width of stall_cycles counter.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  synchronous, active-high reset
- id_rs1  input  5  rs1 of instruction in ID
- id_rs2  input  5  rs2 of instruction in ID
- id_uses_rs1  input  1  ID instruction reads rs1
- id_uses_rs2  input  1  ID instruction reads rs2
- ex_rd  input  5  rd of instruction in EX (ID/EX output)
- ex_mem_read  input  1  EX instruction is a load
- mem_mem_read  input  1  EX/MEM mem_read output
- mem_mem_write  input  1  EX/MEM mem_write output
- redirect_mem  input  1  taken branch or jump resolved in MEM
- dmem_ready  input  1  data memory completes current access
- dmem_req  output  1  data memory request
- dmem_we  output  1  request is a store
- stall_pc  output  1  hold PC
- stall_if_id  output  1  hold IF/ID
- stall_id_ex  output  1  hold ID/EX
- stall_ex_mem  output  1  hold EX/MEM
- flush_if_id  output  1  clear IF/ID
- flush_id_ex  output  1  clear ID/EX
- flush_ex_mem  output  1  clear EX/MEM
- flush_mem_wb  output  1  clear MEM/WB (insert bubble)
- mem_err  output  1  sticky timeout error
- stall_cycles  output  CNT_W  saturating count of stalled cycles

Behaviour:
- All state updates on posedge clk. rst is sampled synchronously and overrides everything in that cycle.
- After reset: state=RUN, wait counter=0, mem_err=0, stall_cycles=0.
- While rst is high, all outputs are 0.

FSM states: RUN, MEM_WAIT, ERR.
- mem_op = mem_mem_read | mem_mem_write.
- RUN:
  - dmem_req = mem_op; dmem_we = mem_mem_write.
  - mem_op & dmem_ready: zero-wait access, no stall, stay RUN.
  - mem_op & ~dmem_ready: mem_stall=1, go MEM_WAIT, wait counter:=1.
- MEM_WAIT:
  - dmem_req=1; dmem_we = mem_mem_write (EX/MEM is held, so inputs are stable).
  - dmem_ready=1: mem_stall=0 in that same cycle, go RUN, counter:=0.
  - Otherwise mem_stall=1. If counter==MEM_TIMEOUT-1, go ERR; else counter+1.
- ERR:
  - dmem_req=0, mem_err=1, all four stalls=1, all flushes=0.
  - Only rst exits.
- mem_err is registered: it first reads 1 in the cycle after the ERR transition edge.

mem_stall = dmem_req & ~dmem_ready (RUN/MEM_WAIT).

Load-use: load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).

Output priority, outside ERR and rst (highest first):
1. mem_stall: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem = 1; flush_mem_wb=1; all other flushes 0. redirect_mem and load_use are ignored this cycle. The redirect is honoured in the first cycle mem_stall drops, because EX/MEM stays held.
2. redirect_mem: flush_if_id, flush_id_ex, flush_ex_mem = 1; no stalls. load_use is ignored because the dependent instruction is being squashed.
3. load_use: stall_pc, stall_if_id = 1; flush_id_ex=1 (bubble).
4. Otherwise all stalls and flushes are 0.
- Outputs are combinational from state plus inputs. No added latency.

stall_cycles:
- Increments by 1 on each clock where any stall_* output is 1 (including ERR).
- Saturates at all-ones and never wraps.
- Cleared only by rst.

Reset mid-access: a rst during MEM_WAIT returns to RUN next cycle with dmem_req=0 and counter=0. The aborted access is not replayed.

Test Plan:
1. Load in EX/MEM, dmem_ready=1 same cycle -> dmem_req=1, dmem_we=0, no stall/flush, stall_cycles stays 0.
2. Store in EX/MEM, dmem_ready low 3 cycles then high -> dmem_we=1; stall_pc/if_id/id_ex/ex_mem and flush_mem_wb high exactly 3 cycles; released in ready cycle; stall_cycles=3.
3. ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> stall_pc=stall_if_id=flush_id_ex=1 for 1 cycle. Repeat with ex_rd=0 -> no stall.
4. redirect_mem=1 with load_use true -> only flush_if_id/id_ex/ex_mem=1, no stalls. With redirect_mem=1 during a 2-cycle MEM_WAIT -> flushes suppressed 2 cycles, asserted in ready cycle.
5. MEM_TIMEOUT=4, dmem_ready never asserted -> stalls 4 cycles in MEM_WAIT, then ERR: dmem_req=0, mem_err=1 from the following cycle, stalls stay high. rst -> mem_err=0, state RUN, stall_cycles=0.
6. CNT_W=3, stall held 10 cycles -> stall_cycles reaches 7 and holds 7.
